// File: rtl/dm_responder_if.sv
// Request/response bundle between the M stage and the data-memory responder.
// The master drives the access; the slave returns data, completion and stall.
interface dm_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic [31:0] rdata;
  logic        done;
  logic        stall;
  logic        addr_err;

  modport master (
    output req, we, addr, wdata, pc,
    input  rdata, done, stall, addr_err
  );

  modport slave (
    input  req, we, addr, wdata, pc,
    output rdata, done, stall, addr_err
  );
endinterface

// File: rtl/dm_responder.sv
// Multi-cycle word RAM serving M-stage loads and stores; stalls the pipeline
// while an access is in flight and returns load data registered.
module dm_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic           clk,
  input  logic           reset,
  dm_responder_if.slave  bus
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT   = CW'(LATENCY - 1);
  localparam logic [32:0]   ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   a_q, d_q, pc_q, rdata_q;
  logic          we_q;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          bad_addr;
  logic          accept;
  logic          commit;
  logic [AW-1:0] word_idx;

  // 33-bit compare so DEPTH_WORDS up to 2^30 cannot overflow the limit.
  assign bad_addr = (bus.addr[1:0] != 2'b00) || ({1'b0, bus.addr} >= ADDR_LIMIT);
  assign accept   = (state_q == S_IDLE) && bus.req && !bad_addr;
  assign commit   = (state_q == S_WAIT) && (cnt_q == '0);
  assign word_idx = a_q[AW+1:2];

  assign bus.addr_err = (state_q == S_IDLE) && bus.req && bad_addr;
  assign bus.stall    = accept || (state_q == S_WAIT);
  assign bus.done     = (state_q == S_RESP);
  assign bus.rdata    = rdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (commit) state_d = S_RESP;
        else        cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      a_q     <= '0;
      we_q    <= 1'b0;
      d_q     <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        a_q  <= bus.addr;
        we_q <= bus.we;
        d_q  <= bus.wdata;
        pc_q <= bus.pc;
      end
      if (commit) rdata_q <= we_q ? 32'h0 : mem_q[word_idx];
`ifndef SYNTHESIS
      if (commit && we_q) $display("@%h: *%h <= %h", pc_q, a_q, d_q);
`endif
    end
  end

  // Reset wipes every word, so a store caught in WAIT by reset never lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (commit && we_q) begin
      mem_q[word_idx] <= d_q;
    end
  end
endmodule

// File: tb/tb_dm_responder.sv
// Drives three responders (LATENCY 1, 2, 4) with one shared access stream and
// scores each against a word-memory model and its expected stall/done timing.
module tb_dm_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [31:0] addr, wdata, pc;
  logic [2:0]  act;
  int          checks = 0;
  int          errors = 0;
  int          lat [3] = '{1, 2, 4};

  dm_responder_if if1 ();
  dm_responder_if if2 ();
  dm_responder_if if4 ();

  dm_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_l1 (.clk(clk), .reset(reset), .bus(if1));
  dm_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_l2 (.clk(clk), .reset(reset), .bus(if2));
  dm_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_l4 (.clk(clk), .reset(reset), .bus(if4));

  assign if1.req = req & act[0];
  assign if2.req = req & act[1];
  assign if4.req = req & act[2];
  assign if1.we = we;    assign if2.we = we;    assign if4.we = we;
  assign if1.addr = addr; assign if2.addr = addr; assign if4.addr = addr;
  assign if1.wdata = wdata; assign if2.wdata = wdata; assign if4.wdata = wdata;
  assign if1.pc = pc;    assign if2.pc = pc;    assign if4.pc = pc;

  logic [2:0]  done_v, stall_v, err_v;
  logic [31:0] rdata_v [3];
  assign done_v  = {if4.done, if2.done, if1.done};
  assign stall_v = {if4.stall, if2.stall, if1.stall};
  assign err_v   = {if4.addr_err, if2.addr_err, if1.addr_err};
  assign rdata_v[0] = if1.rdata;
  assign rdata_v[1] = if2.rdata;
  assign rdata_v[2] = if4.rdata;

  always #5 clk = ~clk;

  logic [31:0] model [int];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] q2 [$];

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    int k = int'(a[31:2]);
    return model.exists(k) ? model[k] : 32'h0;
  endfunction

  function automatic logic [31:0] pop_exp(input int n);
    case (n)
      0:       return (q0.size() != 0) ? q0.pop_front() : 32'hxxxx_xxxx;
      1:       return (q1.size() != 0) ? q1.pop_front() : 32'hxxxx_xxxx;
      default: return (q2.size() != 0) ? q2.pop_front() : 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge with all DUTs idle.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] p, input bit scr);
    int  stall_n [3] = '{0, 0, 0};
    int  done_at [3] = '{-1, -1, -1};
    bit  fin [3]     = '{0, 0, 0};
    logic [31:0] e;
    req = 1'b1; we = w; addr = a; wdata = d; pc = p; act = 3'b111;
    e = w ? 32'h0 : model_rd(a);
    q0.push_back(e); q1.push_back(e); q2.push_back(e);
    if (w) model[int'(a[31:2])] = d;
    $display("access %s addr=%h wdata=%h pc=%h expect rdata=%h", w ? "sw" : "lw", a, d, p, e);
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      for (int n = 0; n < 3; n++) begin
        if (!fin[n]) begin
          chk($sformatf("L%0d_exclusive", lat[n]),
              32'($countones({done_v[n], stall_v[n], err_v[n]}) <= 1), 32'd1);
          if (stall_v[n]) stall_n[n]++;
          if (done_v[n]) begin
            fin[n] = 1'b1;
            done_at[n] = cyc;
            act[n] = 1'b0;
            chk($sformatf("L%0d_rdata@%h", lat[n], a), rdata_v[n], pop_exp(n));
          end
        end
      end
      if (scr && cyc == 1) begin
        addr = a ^ 32'h40;
        wdata = ~d;
      end
      @(posedge clk); #1;
      if (fin[0] && fin[1] && fin[2]) break;
    end
    req = 1'b0;
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("L%0d_done_seen", lat[n]), 32'(fin[n]), 32'd1);
      chk($sformatf("L%0d_stall_width", lat[n]), 32'(stall_n[n]), 32'(lat[n] + 1));
      chk($sformatf("L%0d_done_cycle", lat[n]), 32'(done_at[n]), 32'(lat[n] + 1));
    end
  endtask

  task automatic bad_req(input logic [31:0] a);
    req = 1'b1; we = 1'b1; addr = a; wdata = 32'hBAD0_BAD0; pc = 32'h0000_6000; act = 3'b111;
    $display("bad request addr=%h", a);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("addr_err", 32'(err_v), 32'h7);
      chk("err_stall", 32'(stall_v), 32'h0);
      chk("err_done", 32'(done_v), 32'h0);
      @(posedge clk); #1;
    end
    req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; pc = '0; act = 3'b111;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("L%0d_reset_done", lat[n]), 32'(done_v[n]), 32'h0);
      chk($sformatf("L%0d_reset_stall", lat[n]), 32'(stall_v[n]), 32'h0);
      chk($sformatf("L%0d_reset_rdata", lat[n]), rdata_v[n], 32'h0);
    end
    @(posedge clk); #1;

    // T1: top word after reset reads zero
    access(1'b0, 32'h0000_0FFC, 32'h0, 32'h0000_0100, 1'b0);

    // T2: store then load returns the new data
    access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_3000, 1'b0);
    access(1'b0, 32'h0000_0010, 32'h0, 32'h0000_3004, 1'b0);

    // T3: misaligned and out-of-range requests are refused and write nothing
    access(1'b1, 32'h0000_0000, 32'h0BAD_F00D, 32'h0000_3008, 1'b0);
    bad_req(32'h0000_0013);
    bad_req(32'h0000_1000);
    access(1'b0, 32'h0000_0000, 32'h0, 32'h0000_300C, 1'b0);
    access(1'b0, 32'h0000_0010, 32'h0, 32'h0000_3010, 1'b0);

    // T4: reset while a store is pending in WAIT
    req = 1'b1; we = 1'b1; addr = 32'h0000_0020; wdata = 32'h0000_1234; pc = 32'h0000_5000;
    act = 3'b111;
    $display("store 0x20 interrupted by reset");
    @(posedge clk); #1;
    @(negedge clk);
    chk("midreset_stall", 32'(stall_v), 32'h7);
    reset = 1'b1; req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model.delete();
    @(negedge clk);
    chk("postreset_stall", 32'(stall_v), 32'h0);
    chk("postreset_done", 32'(done_v), 32'h0);
    for (int n = 0; n < 3; n++)
      chk($sformatf("L%0d_postreset_rdata", lat[n]), rdata_v[n], 32'h0);
    @(posedge clk); #1;
    access(1'b0, 32'h0000_0020, 32'h0, 32'h0000_5004, 1'b0);

    // T5: inputs altered during WAIT are ignored
    access(1'b1, 32'h0000_0080, 32'hA5A5_0001, 32'h0000_4000, 1'b1);
    access(1'b0, 32'h0000_0080, 32'h0, 32'h0000_4004, 1'b1);
    access(1'b0, 32'h0000_00C0, 32'h0, 32'h0000_4008, 1'b0);

    // T6: back-to-back accesses touch only their own words
    access(1'b1, 32'h0000_0100, 32'h1111_1111, 32'h0000_7000, 1'b0);
    access(1'b1, 32'h0000_0104, 32'h2222_2222, 32'h0000_7004, 1'b0);
    access(1'b1, 32'h0000_0FFC, 32'h3333_3333, 32'h0000_7008, 1'b0);
    access(1'b0, 32'h0000_0100, 32'h0, 32'h0000_700C, 1'b0);
    access(1'b0, 32'h0000_0104, 32'h0, 32'h0000_7010, 1'b0);
    access(1'b0, 32'h0000_0108, 32'h0, 32'h0000_7014, 1'b0);
    access(1'b0, 32'h0000_0FFC, 32'h0, 32'h0000_7018, 1'b0);
    access(1'b0, 32'h0000_0080, 32'h0, 32'h0000_701C, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
